// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and the ALU operation encoding used by the
// integer datapath.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  // funct3 mapping shared by OP (funct7=0x00) and OP-IMM.
  function automatic alu_op_e base_op(input logic [2:0] funct3);
    case (funct3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e muldiv_op(input logic [2:0] funct3);
    case (funct3)
      3'd0:    return ALU_MUL;
      3'd1:    return ALU_MULH;
      3'd2:    return ALU_MULHSU;
      3'd3:    return ALU_MULHU;
      3'd4:    return ALU_DIV;
      3'd5:    return ALU_DIVU;
      3'd6:    return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of OP / OP-IMM / LUI into ALU control, operand select,
// immediate and register indices; anything unrecognised is flagged illegal.
module instr_decode
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]     instr,
  output logic            legal,
  output logic [4:0]      alu_op,
  output logic            alu_src_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            regwrite
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic signed [11:0] imm_i;
  logic signed [31:0] imm_u;
  logic              is_shift;
  logic              shift_ok;
  alu_op_e           op;
  logic              ok;
  logic              src_imm;
  logic [XLEN-1:0]   imm_val;
  logic [4:0]        rs1_val;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign imm_i    = instr[31:20];
  assign imm_u    = {instr[31:12], 12'b0};
  assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);

  // RV64 shamt is 6 bits wide, so only instr[31:26] carries the funct field.
  always_comb begin
    shift_ok = 1'b0;
    if (XLEN == 64) begin
      shift_ok = (instr[31:26] == 6'h00) ||
                 ((instr[31:26] == 6'h10) && (funct3 == 3'd5));
    end else begin
      shift_ok = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && (funct3 == 3'd5));
    end
  end

  always_comb begin
    ok      = 1'b0;
    op      = ALU_ADD;
    src_imm = 1'b0;
    imm_val = '0;
    rs1_val = instr[19:15];
    case (opcode)
      OPC_OP: begin
        case (funct7)
          F7_BASE: begin
            ok = 1'b1;
            op = base_op(funct3);
          end
          F7_ALT: begin
            if (funct3 == 3'd0) begin
              ok = 1'b1;
              op = ALU_SUB;
            end else if (funct3 == 3'd5) begin
              ok = 1'b1;
              op = ALU_SRA;
            end
          end
          F7_MULDIV: begin
            if (ENABLE_M) begin
              ok = 1'b1;
              op = muldiv_op(funct3);
            end
          end
          default: ok = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        src_imm = 1'b1;
        if (is_shift) begin
          ok = shift_ok;
          if (funct3 == 3'd1) op = ALU_SLL;
          else                op = instr[30] ? ALU_SRA : ALU_SRL;
          if (XLEN == 64) imm_val = XLEN'(instr[25:20]);
          else            imm_val = XLEN'(instr[24:20]);
        end else begin
          ok      = 1'b1;
          op      = base_op(funct3);
          imm_val = XLEN'(imm_i);
        end
      end
      OPC_LUI: begin
        ok      = 1'b1;
        op      = ALU_ADD;
        src_imm = 1'b1;
        rs1_val = 5'd0;
        imm_val = XLEN'(imm_u);
      end
      default: ok = 1'b0;
    endcase
  end

  // Illegal words become a harmless non-writing ADD so nothing stale leaks out.
  always_comb begin
    legal       = ok;
    alu_op      = ok ? op : ALU_ADD;
    alu_src_imm = ok & src_imm;
    imm         = ok ? imm_val : '0;
    rs1         = ok ? rs1_val : instr[19:15];
    rs2         = instr[24:20];
    rd          = instr[11:7];
    regwrite    = ok && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_decode_stage.sv
// One-entry valid/ready pipeline register around instr_decode, plus a
// saturating counter of accepted illegal instructions.
module alu_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit ENABLE_M  = 1'b0,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           alu_control,
  output logic                 regwrite_control,
  output logic                 alu_src_imm,
  output logic [XLEN-1:0]      imm,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  logic            dec_legal;
  logic [4:0]      dec_alu_op;
  logic            dec_src_imm;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic            dec_regwrite;

  instr_decode #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .instr       (instr),
    .legal       (dec_legal),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_src_imm),
    .imm         (dec_imm),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .rd          (dec_rd),
    .regwrite    (dec_regwrite)
  );

  logic                 valid_reg;
  logic [4:0]           alu_op_reg;
  logic                 regwrite_reg;
  logic                 src_imm_reg;
  logic [XLEN-1:0]      imm_reg;
  logic [4:0]           rs1_reg;
  logic [4:0]           rs2_reg;
  logic [4:0]           rd_reg;
  logic                 illegal_reg;
  logic [ILL_CNT_W-1:0] ill_cnt_reg;
  logic [ILL_CNT_W-1:0] ill_cnt_next;
  logic                 accept;

  assign in_ready = !valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ill_cnt_next = ill_cnt_reg;
    if (accept && !dec_legal && !(&ill_cnt_reg))
      ill_cnt_next = ill_cnt_reg + ILL_CNT_W'(1);
  end

  // Payload only loads on a non-flushed accept, so a stalled entry holds still.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      alu_op_reg   <= '0;
      regwrite_reg <= 1'b0;
      src_imm_reg  <= 1'b0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
      illegal_reg  <= 1'b0;
      ill_cnt_reg  <= '0;
    end else begin
      ill_cnt_reg <= ill_cnt_next;
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (accept) begin
        valid_reg    <= 1'b1;
        alu_op_reg   <= dec_alu_op;
        regwrite_reg <= dec_regwrite;
        src_imm_reg  <= dec_src_imm;
        imm_reg      <= dec_imm;
        rs1_reg      <= dec_rs1;
        rs2_reg      <= dec_rs2;
        rd_reg       <= dec_rd;
        illegal_reg  <= !dec_legal;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid        = valid_reg;
  assign alu_control      = alu_op_reg;
  assign regwrite_control = regwrite_reg;
  assign alu_src_imm      = src_imm_reg;
  assign imm              = imm_reg;
  assign rs1              = rs1_reg;
  assign rs2              = rs2_reg;
  assign rd               = rd_reg;
  assign illegal          = illegal_reg;
  assign ill_count        = ill_cnt_reg;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench: four parameterisations of alu_decode_stage share one
// stimulus stream and are checked against hand-computed values.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic        flush;
  logic        out_ready;

  always #5 clk = ~clk;

  // a: XLEN=32 M=0 W=16   m: XLEN=32 M=1   w: XLEN=64 M=0   s: ILL_CNT_W=2
  logic        a_in_ready, a_out_valid, a_regwrite, a_src_imm, a_illegal;
  logic [4:0]  a_alu, a_rs1, a_rs2, a_rd;
  logic [31:0] a_imm;
  logic [15:0] a_cnt;
  logic        m_in_ready, m_out_valid, m_regwrite, m_src_imm, m_illegal;
  logic [4:0]  m_alu, m_rs1, m_rs2, m_rd;
  logic [31:0] m_imm;
  logic [15:0] m_cnt;
  logic        w_in_ready, w_out_valid, w_regwrite, w_src_imm, w_illegal;
  logic [4:0]  w_alu, w_rs1, w_rs2, w_rd;
  logic [63:0] w_imm;
  logic [15:0] w_cnt;
  logic        s_in_ready, s_out_valid, s_regwrite, s_src_imm, s_illegal;
  logic [4:0]  s_alu, s_rs1, s_rs2, s_rd;
  logic [31:0] s_imm;
  logic [1:0]  s_cnt;

  alu_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ILL_CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .alu_control(a_alu), .regwrite_control(a_regwrite), .alu_src_imm(a_src_imm),
    .imm(a_imm), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .illegal(a_illegal),
    .ill_count(a_cnt));

  alu_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ILL_CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .instr(instr), .flush(flush), .out_valid(m_out_valid), .out_ready(out_ready),
    .alu_control(m_alu), .regwrite_control(m_regwrite), .alu_src_imm(m_src_imm),
    .imm(m_imm), .rs1(m_rs1), .rs2(m_rs2), .rd(m_rd), .illegal(m_illegal),
    .ill_count(m_cnt));

  alu_decode_stage #(.XLEN(64), .ENABLE_M(1'b0), .ILL_CNT_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .instr(instr), .flush(flush), .out_valid(w_out_valid), .out_ready(out_ready),
    .alu_control(w_alu), .regwrite_control(w_regwrite), .alu_src_imm(w_src_imm),
    .imm(w_imm), .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd), .illegal(w_illegal),
    .ill_count(w_cnt));

  alu_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ILL_CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .instr(instr), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
    .alu_control(s_alu), .regwrite_control(s_regwrite), .alu_src_imm(s_src_imm),
    .imm(s_imm), .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd), .illegal(s_illegal),
    .ill_count(s_cnt));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'h0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    check("rst_valid", a_out_valid, 0);
    check("rst_alu", a_alu, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_imm64", w_imm, 0);
    check("rst_in_ready", a_in_ready, 1);

    rst_n = 1'b1; in_valid = 1'b1;
    instr = 32'h002081B3; step();   // add x3,x1,x2
    check("add_valid", a_out_valid, 1);
    check("add_alu", a_alu, 0);
    check("add_rs1", a_rs1, 1);
    check("add_rs2", a_rs2, 2);
    check("add_rd", a_rd, 3);
    check("add_we", a_regwrite, 1);
    check("add_ill", a_illegal, 0);
    check("add_src", a_src_imm, 0);

    instr = 32'h40208133; step();   // sub x2,x1,x2
    check("sub_alu", a_alu, 1);
    check("sub_rd", a_rd, 2);

    instr = 32'h022081B3; step();   // mul x3,x1,x2
    check("mul_ill_a", a_illegal, 1);
    check("mul_we_a", a_regwrite, 0);
    check("mul_alu_a", a_alu, 0);
    check("mul_cnt_a", a_cnt, 1);
    check("mul_rd_a", a_rd, 3);
    check("mul_alu_m", m_alu, 10);
    check("mul_ill_m", m_illegal, 0);
    check("mul_we_m", m_regwrite, 1);
    check("mul_cnt_m", m_cnt, 0);

    instr = 32'hFFF00093; step();   // addi x1,x0,-1
    check("addi_src", a_src_imm, 1);
    check("addi_imm", a_imm, 32'hFFFF_FFFF);
    check("addi_imm64", w_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_alu", a_alu, 0);
    check("addi_rd", a_rd, 1);

    instr = 32'h42835293; step();   // srai x5,x6,40
    check("srai64_alu", w_alu, 7);
    check("srai64_imm", w_imm, 40);
    check("srai64_ill", w_illegal, 0);
    check("srai64_rs1", w_rs1, 6);
    check("srai32_ill", a_illegal, 1);
    check("srai32_imm", a_imm, 0);
    check("srai32_cnt", a_cnt, 2);

    instr = 32'h40535293; step();   // srai x5,x6,5
    check("srai32ok_alu", a_alu, 7);
    check("srai32ok_imm", a_imm, 5);

    instr = 32'h123450B7; step();   // lui x1,0x12345
    check("lui_imm", a_imm, 32'h1234_5000);
    check("lui_src", a_src_imm, 1);
    check("lui_rs1", a_rs1, 0);
    check("lui_alu", a_alu, 0);

    instr = 32'h800000B7; step();   // lui x1,0x80000
    check("lui_neg64", w_imm, 64'hFFFF_FFFF_8000_0000);

    // backpressure
    in_valid = 1'b0; step();
    check("drain_valid", a_out_valid, 0);
    in_valid = 1'b1; out_ready = 1'b0;
    instr = 32'h00A00513; step();   // addi x10,x0,10
    check("bp_first_rd", a_rd, 10);
    instr = 32'h01400593;           // addi x11,x0,20
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", a_in_ready, 0);
      step();
      check("bp_hold_valid", a_out_valid, 1);
      check("bp_hold_imm", a_imm, 10);
      check("bp_hold_rd", a_rd, 10);
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", a_in_ready, 1);
    step();
    check("bp_second_rd", a_rd, 11);
    check("bp_second_imm", a_imm, 20);
    in_valid = 1'b0; step();
    check("bp_empty", a_out_valid, 0);

    // flush while stalled, then flush racing an illegal accept
    in_valid = 1'b1; out_ready = 1'b0; instr = 32'h00A00513; step();
    check("fl_valid", a_out_valid, 1);
    flush = 1'b1; step();
    check("fl_stall", a_out_valid, 0);
    instr = 32'hFFFF_FFFF; step();
    check("fl_drop", a_out_valid, 0);
    check("fl_cnt_a", a_cnt, 3);
    check("fl_cnt_s", s_cnt, 3);
    flush = 1'b0; out_ready = 1'b1;

    // saturation: two more illegal words
    step(); step();
    check("sat_cnt_s", s_cnt, 3);
    check("sat_cnt_a", a_cnt, 5);
    check("sat_ill", s_illegal, 1);

    // reset mid-stream
    instr = 32'h002081B3; step();
    check("pre_rst_rd", a_rd, 3);
    rst_n = 1'b0; step();
    check("mrst_valid", a_out_valid, 0);
    check("mrst_cnt", a_cnt, 0);
    check("mrst_cnt_s", s_cnt, 0);
    check("mrst_rd", a_rd, 0);
    check("mrst_rs1", a_rs1, 0);
    check("mrst_we", a_regwrite, 0);
    check("mrst_imm64", w_imm, 0);
    rst_n = 1'b1; step();
    check("post_rst_valid", a_out_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered instruction-decode stage for the RISC-V integer datapath. It decodes OP (R-type), OP-IMM (I-type) and LUI instructions into ALU control, operand select, immediate and register indices, and flags illegal encodings instead of holding stale outputs. A one-entry valid/ready pipeline register sits between fetch and the register file / ALU. XLEN and an optional M-extension decode are selected by parameters.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- ENABLE_M, 0: when 1, decode OP with funct7=0x01 as M-extension ops.
- ILL_CNT_W, 16: width of the saturating illegal-instruction counter.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage accepts instr this cycle.
- instr  in  32  raw instruction word.
- flush  in  1  drop the registered entry.
- out_valid  out  1  decoded entry is valid.
- out_ready  in  1  consumer takes the entry this cycle.
- alu_control  out  5  ALU operation code (alu_op_e).
- regwrite_control  out  1  write rd.
- alu_src_imm  out  1  operand B is imm, not rs2.
- imm  out  XLEN  sign-extended immediate.
- rs1, rs2, rd  out  5 each  register indices.
- illegal  out  1  entry is an illegal instruction.
- ill_count  out  ILL_CNT_W  saturating count of accepted illegal instructions.

## Operation
- alu_op_e codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17.
- OP (0x33), funct7=0x00: funct3 0..7 map to ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
- OP, funct7=0x20: funct3=0 gives SUB and funct3=5 gives SRA. Every other funct3 with funct7=0x20 is illegal.
- OP, funct7=0x01: with ENABLE_M=1, funct3 0..7 map to MUL..REMU. With ENABLE_M=0 it is illegal. Any other funct7 is illegal.
- OP-IMM (0x13): funct3 selects the same ops as OP with funct7=0x00; alu_src_imm=1; imm=sign-extended instr[31:20].
- OP-IMM shifts, XLEN=32: instr[31:25] must be 0x00 (SLLI, SRLI) or 0x20 (SRAI), else illegal; imm=instr[24:20].
- OP-IMM shifts, XLEN=64: instr[31:26] must be 0x00 or 0x10; imm=instr[25:20].
- LUI (0x37): alu ADD, alu_src_imm=1, rs1 forced to 0, imm={instr[31:12],12'b0} sign-extended to XLEN.
- Any other opcode is illegal.
- Illegal entry: illegal=1, regwrite_control=0, alu_control=ADD, alu_src_imm=0, imm=0; rs1/rs2/rd are still the raw instruction fields.
- regwrite_control = legal && rd!=0.
- rs2 = instr[24:20] for all formats; ignored when alu_src_imm=1.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, every decoded output=0, ill_count=0. Reset overrides flush and accept.
- Accept condition: in_valid && in_ready, where in_ready = !out_valid || out_ready (combinational).
- Latency 1 cycle; throughput 1 instruction/cycle with out_ready held high.
- While out_valid && !out_ready, all outputs hold stable and in_ready=0.
- flush: next cycle out_valid=0; a same-cycle accept is dropped. ill_count still counts an illegal instruction accepted in that cycle.
- Simultaneous consume and accept: the register is replaced with no bubble.
- ill_count increments by 1 on each accepted illegal instruction and saturates at all-ones.

## Structure
- Package riscv_pkg holds: opcode constants OPC_OP/OPC_OP_IMM/OPC_LUI, funct7 constants F7_BASE/F7_ALT/F7_MULDIV, and the 5-bit alu_op_e enum.
- Sub-module instr_decode: purely combinational, parameterised by XLEN/ENABLE_M, with default assignments (no latches).
- alu_decode_stage: handshake, pipeline register and counter.

## Test plan
- Basic R-type: 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, alu_control=0, rs1=1, rs2=2, rd=3, regwrite_control=1, illegal=0.
- SUB and M decode: 0x40208133 -> alu_control=1. Then 0x022081B3 with ENABLE_M=0 -> illegal=1, regwrite_control=0, ill_count=1. With ENABLE_M=1 the same word gives alu_control=10.
- Immediate: 0xFFF00093 (addi x1,x0,-1) -> alu_src_imm=1, imm=0xFFFFFFFF, alu_control=0.
- XLEN=64 shift: 0x42835293 (srai x5,x6,40) -> alu_control=7, imm=40. The same word in XLEN=32 -> illegal=1.
- Backpressure/flush: two instructions with out_ready=0 for 3 cycles -> first held stable, in_ready=0; second appears the cycle after out_ready=1. Asserting flush while stalled -> out_valid=0 next cycle.
- Saturation/reset: ILL_CNT_W=2, feed 5 illegal words -> ill_count=3. Assert rst_n=0 mid-stream -> all outputs 0 after the edge.
